invsqrt_scheduler: RTL and testbench
====================================

# invsqrt_scheduler

Round-robin scheduler that shares one fully pipelined inverse-square-root datapath among NUM_REQ requesters. It accepts one operand per cycle through per-requester valid/ready handshakes and tags each issued operand with its requester index. The tag travels through a shadow shift register matched to the datapath latency, and each result is returned to the requester that issued it. The block sits between the client logic and the inverse-square-root core; it drives the core's operand input and consumes the core's result output.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- PIPE_LAT, 4: datapath latency in cycles, from operand in to result out. Must equal the instantiated core's latency; valid range 1..32.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  32*NUM_REQ  IEEE-754 single operands; requester i occupies bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high.
- flush  in  1  level request to stop issuing and drain the pipeline.
- flush_done  out  1  high while in DRAINED state.
- dp_data_in  out  32  operand to core.
- dp_data_out  in  32  result from core.
- resp_valid  out  NUM_REQ  one-hot, single-cycle result strobe; no backpressure.
- resp_data  out  32  result, valid when any resp_valid bit is set.
- inflight  out  6  count of occupied pipeline slots.

## Operation
- Arbiter: round-robin over req_valid, starting from the index after the last granted requester (pointer resets to NUM_REQ-1, so requester 0 wins first). req_ready is combinational from req_valid, the pointer, and the state. At most one bit is set. req_ready is all-zero outside RUN.
- Issue: on a grant, dp_data_in = the granted operand. With no grant, dp_data_in = 0. The shadow register stage 0 loads {valid=1, tag=index, code}; otherwise it loads valid=0.
- Shadow register: PIPE_LAT stages of {valid, tag[2:0], code[1:0]}, shifting every cycle unconditionally.
- Result return: when the last stage has valid=1, resp_valid[tag] pulses for one cycle. resp_data is taken from dp_data_out (code=0) or from the special value selected by code.
- inflight: +1 on issue, −1 on retire. On a simultaneous issue and retire it is unchanged. Its maximum is PIPE_LAT.
- FSM:
  - RUN: normal issuing. Goes to DRAIN when flush=1.
  - DRAIN: no grants. Goes to DRAINED when inflight==0. Goes to RUN if flush drops before then.
  - DRAINED: flush_done=1. Goes to RUN when flush=0.
  - If flush rises in the same cycle as a grant, that grant still completes: req_ready is evaluated in RUN that cycle.
- Reset mid-operation clears all in-flight tags. Results still emerging from the core are discarded; no resp_valid is produced for them.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_data=0, dp_data_in=0 (combinational from the reset state).
  - flush_done=0, inflight=0, all shadow valid bits=0, state=RUN, RR pointer=NUM_REQ-1.
- Throughput: one issue per cycle, sustained.
- Latency: an operand accepted at edge N produces resp_valid at edge N+PIPE_LAT. Responses are registered and aligned to the core's output stage.
- Issue order equals response order. Results are never reordered.
- Requesters must accept responses unconditionally.

## Configuration
- INVSQRT_SCHED_SPECIAL_EN defined: each operand is screened at issue. The code field records:
  - sign=1 and nonzero: code 1, returns 0x7FC00000 (NaN).
  - ±0: code 2, returns 0x7F800000 (+Inf).
  - exponent 0xFF: code 3, returns 0x7FC00000.
  - Screened operands still consume a slot, so ordering and latency are unchanged. dp_data_in is driven to 0 for them.
- Macro undefined: code is always 0. Every operand goes to the core, and resp_data always equals dp_data_out.

## Test plan
- Single requester 0 sends 0x40800000 (4.0) → resp_valid[0] exactly PIPE_LAT cycles later, resp_data within 0.2% of 0x3F000000 (0.5).
- All four requesters hold valid with distinct operands for 8 cycles → grants 0,1,2,3,0,1,2,3. Each resp_valid[i] carries its own operand's result, in the same order.
- Continuous issue, then flush=1 → req_ready goes to 0 next cycle. flush_done rises exactly when inflight reaches 0, PIPE_LAT cycles after the last grant. Dropping flush resumes grants on the following cycle.
- rst pulsed low with 3 operations in flight → inflight=0 and no resp_valid within PIPE_LAT cycles after release.
- With INVSQRT_SCHED_SPECIAL_EN:
  - operand 0xBF800000 (−1.0) → resp_data 0x7FC00000.
  - operand 0x00000000 → 0x7F800000.
  - each at latency PIPE_LAT, interleaved correctly with normal operands.
- Simultaneous issue and retire at full load → inflight holds at PIPE_LAT and never exceeds it.

Source files
------------

// File: rtl/invsqrt_scheduler.sv
// rtl/invsqrt_scheduler.sv - round-robin scheduler sharing one pipelined inverse-sqrt core
//
// Purpose: accepts one operand per cycle from NUM_REQ requesters (round-robin),
// drives it into a PIPE_LAT-deep inverse-square-root core, and carries each
// operand's requester tag along a matching shadow shift register so the core
// result is routed back to the requester that issued it.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    per-requester operand valid
//   req_data     packed operands, requester i at [32i+31:32i]
//   req_ready    one-hot grant (combinational)
//   flush        level request to stop issuing and drain
//   flush_done   high while drained
//   dp_data_in   operand to core
//   dp_data_out  result from core
//   resp_valid   one-hot single-cycle result strobe
//   resp_data    result, zero when no strobe
//   inflight     occupied pipeline slots
//
// Optional feature: define INVSQRT_SCHED_SPECIAL_EN to screen negative, zero
// and Inf/NaN operands at issue and return fixed special results for them.

module invsqrt_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [31:0]           dp_data_in,
    input  logic [31:0]           dp_data_out,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_data,
    output logic [5:0]            inflight
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  rr_ptr;
    logic [2:0]  grant_idx;
    logic        issue;
    logic [31:0] operand;
    logic [1:0]  code;
    logic        retire;
    logic [5:0]  inflight_next;

    logic        sh_valid [PIPE_LAT];
    logic [2:0]  sh_tag   [PIPE_LAT];
    logic [1:0]  sh_code  [PIPE_LAT];

    // Requester index k positions after base, wrapping at NUM_REQ.
    function automatic int rr_index(input logic [2:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum;
    endfunction

    // Search starts just after the last winner. Grants are suppressed while
    // reset is held so no transfer can be lost to a clearing shadow register.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        issue     = 1'b0;
        if (state == ST_RUN && rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!issue && req_valid[rr_index(rr_ptr, k)]) begin
                    issue                             = 1'b1;
                    grant_idx                         = 3'(rr_index(rr_ptr, k));
                    req_ready[rr_index(rr_ptr, k)]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) operand = req_data[32*i +: 32];
        end
    end

`ifdef INVSQRT_SCHED_SPECIAL_EN
    // Zero is tested before sign so that -0 maps to +Inf like +0.
    always_comb begin
        code = 2'd0;
        if (operand[30:0] == 31'd0)        code = 2'd2;
        else if (operand[31])              code = 2'd1;
        else if (operand[30:23] == 8'hFF)  code = 2'd3;
    end
`else
    assign code = 2'd0;
`endif

    // Screened operands still occupy a slot but feed the core a zero.
    assign dp_data_in = (issue && code == 2'd0) ? operand : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                sh_valid[i] <= 1'b0;
                sh_tag[i]   <= 3'd0;
                sh_code[i]  <= 2'd0;
            end
        end else begin
            sh_valid[0] <= issue;
            sh_tag[0]   <= grant_idx;
            sh_code[0]  <= code;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_tag[i]   <= sh_tag[i-1];
                sh_code[i]  <= sh_code[i-1];
            end
        end
    end

    // The last shadow stage lines up with the core's output register, so the
    // response is decoded directly from it with dp_data_out alongside.
    assign retire = sh_valid[PIPE_LAT-1];

    always_comb begin
        resp_valid = '0;
        resp_data  = 32'd0;
        if (retire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sh_tag[PIPE_LAT-1] == 3'(i)) resp_valid[i] = 1'b1;
            end
            case (sh_code[PIPE_LAT-1])
                2'd0:    resp_data = dp_data_out;
                2'd2:    resp_data = 32'h7F80_0000;
                default: resp_data = 32'h7FC0_0000;
            endcase
        end
    end

    always_comb begin
        inflight_next = inflight;
        if (issue && !retire)      inflight_next = inflight + 6'd1;
        else if (!issue && retire) inflight_next = inflight - 6'd1;
    end

    // DRAIN looks at the next count so flush_done rises on the same edge
    // that retires the last slot.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (flush) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!flush)                    state_next = ST_RUN;
                else if (inflight_next == 6'd0) state_next = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!flush) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign flush_done = (state == ST_DRAINED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            inflight <= 6'd0;
            rr_ptr   <= 3'(NUM_REQ - 1);
        end else begin
            state    <= state_next;
            inflight <= inflight_next;
            if (issue) rr_ptr <= grant_idx;
        end
    end

endmodule

// File: tb/tb_invsqrt_scheduler.sv
// tb/tb_invsqrt_scheduler.sv - directed self-checking bench for invsqrt_scheduler

module tb_invsqrt_scheduler;

    localparam int NR = 4;
    localparam int PL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [32*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            flush;
    logic            flush_done;
    logic [31:0]     dp_data_in;
    logic [31:0]     dp_data_out;
    logic [NR-1:0]   resp_valid;
    logic [31:0]     resp_data;
    logic [5:0]      inflight;

    int tests = 0;
    int fails = 0;

    logic [31:0] ops     [4];
    logic [31:0] exp_dp  [4];
    logic [31:0] exp_res [4];
    logic [31:0] core_pipe [PL];

    always #5 clk = ~clk;

    invsqrt_scheduler #(.NUM_REQ(NR), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .flush_done(flush_done),
        .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .inflight(inflight)
    );

    // Core stand-in: exact 1/sqrt for the powers of four used below,
    // a recognisable scramble for anything else.
    function automatic logic [31:0] core_f(input logic [31:0] x);
        case (x)
            32'h4080_0000: core_f = 32'h3F00_0000;
            32'h3F80_0000: core_f = 32'h3F80_0000;
            32'h4180_0000: core_f = 32'h3E80_0000;
            32'h3E80_0000: core_f = 32'h4000_0000;
            default:       core_f = x ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= core_f(dp_data_in);
        for (int i = 1; i < PL; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign dp_data_out = core_pipe[PL-1];

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Slots occupied in cycle t when operands were issued in cycles first..last.
    function automatic int exp_inflight(input int t, input int first, input int last);
        int lo, hi;
        lo = (t - PL > first) ? t - PL : first;
        hi = (t - 1 < last) ? t - 1 : last;
        return (hi >= lo) ? hi - lo + 1 : 0;
    endfunction

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; req_valid = '0; req_data = '0;
        step; step;
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_req_ready: got %h want 0", req_ready); end
        tests++; if (resp_valid !== 4'h0) begin fails++; $display("FAIL reset_resp_valid: got %h want 0", resp_valid); end
        tests++; if (resp_data !== 32'h0) begin fails++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        tests++; if (dp_data_in !== 32'h0) begin fails++; $display("FAIL reset_dp_data_in: got %h want 0", dp_data_in); end
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        tests++; if (inflight !== 6'd0) begin fails++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        req_valid = 4'hF; #1;
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_no_grant: got %h want 0", req_ready); end
        req_valid = '0;
        step;
        rst = 1'b1;
    endtask

    task automatic test_round_robin;
        ops[0] = 32'h4080_0000; ops[1] = 32'h3F80_0000;
        ops[2] = 32'h4180_0000; ops[3] = 32'h3E80_0000;
        req_data = {ops[3], ops[2], ops[1], ops[0]};
        for (int t = 0; t < 8 + PL + 2; t++) begin
            req_valid = (t < 8) ? 4'hF : 4'h0;
            #1;
            if (t < 8) begin
                tests++; if (req_ready !== 4'(1 << (t % 4))) begin fails++; $display("FAIL rr_grant t=%0d: got %h want %h", t, req_ready, 4'(1 << (t % 4))); end
                tests++; if (dp_data_in !== ops[t % 4]) begin fails++; $display("FAIL rr_dp_data_in t=%0d: got %h want %h", t, dp_data_in, ops[t % 4]); end
            end
            if (t - PL >= 0 && t - PL < 8) begin
                tests++; if (resp_valid !== 4'(1 << ((t - PL) % 4))) begin fails++; $display("FAIL rr_resp_valid t=%0d: got %h want %h", t, resp_valid, 4'(1 << ((t - PL) % 4))); end
                tests++; if (resp_data !== core_f(ops[(t - PL) % 4])) begin fails++; $display("FAIL rr_resp_data t=%0d: got %h want %h", t, resp_data, core_f(ops[(t - PL) % 4])); end
            end else begin
                tests++; if (resp_valid !== 4'h0) begin fails++; $display("FAIL rr_resp_idle t=%0d: got %h want 0", t, resp_valid); end
            end
            tests++; if (inflight !== 6'(exp_inflight(t, 0, 7))) begin fails++; $display("FAIL full_load_inflight t=%0d: got %0d want %0d", t, inflight, exp_inflight(t, 0, 7)); end
            step;
        end
    endtask

    task automatic test_single;
        req_data = '0;
        req_data[31:0] = 32'h4080_0000;
        req_valid = 4'h1;
        #1;
        tests++; if (req_ready !== 4'h1) begin fails++; $display("FAIL single_grant: got %h want 1", req_ready); end
        tests++; if (dp_data_in !== 32'h4080_0000) begin fails++; $display("FAIL single_dp_data_in: got %h want 40800000", dp_data_in); end
        step;
        req_valid = 4'h0;
        for (int j = 0; j <= PL; j++) begin
            tests++; if (resp_valid !== ((j == PL - 1) ? 4'h1 : 4'h0)) begin fails++; $display("FAIL single_latency j=%0d: got %h want %h", j, resp_valid, (j == PL - 1) ? 4'h1 : 4'h0); end
            if (j == PL - 1) begin
                tests++; if (resp_data !== 32'h3F00_0000) begin fails++; $display("FAIL single_resp_data: got %h want 3f000000", resp_data); end
            end
            step;
        end
    endtask

    task automatic test_flush;
        req_data = {ops[3], ops[2], ops[1], ops[0]};
        for (int t = 0; t < 12; t++) begin
            flush = (t >= 3 && t < 10);
            req_valid = 4'hF;
            #1;
            if (t <= 3) begin
                tests++; if (req_ready !== 4'(1 << ((t + 1) % 4))) begin fails++; $display("FAIL flush_pre_grant t=%0d: got %h want %h", t, req_ready, 4'(1 << ((t + 1) % 4))); end
            end else if (t <= 10) begin
                tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL flush_blocked t=%0d: got %h want 0", t, req_ready); end
                tests++; if (flush_done !== (t >= 8)) begin fails++; $display("FAIL flush_done t=%0d: got %b want %b", t, flush_done, t >= 8); end
                tests++; if (inflight !== 6'(exp_inflight(t, 0, 3))) begin fails++; $display("FAIL flush_inflight t=%0d: got %0d want %0d", t, inflight, exp_inflight(t, 0, 3)); end
            end else begin
                tests++; if (req_ready !== 4'h2) begin fails++; $display("FAIL flush_resume: got %h want 2", req_ready); end
                tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL flush_done_clear: got %b want 0", flush_done); end
            end
            step;
        end
        req_valid = 4'h0;
        for (int j = 0; j < PL + 2; j++) step;
    endtask

    task automatic test_reset_midflight;
        req_data = '0;
        req_data[31:0] = 32'h3F80_0000;
        req_valid = 4'h1;
        step; step; step;
        req_valid = 4'h0;
        tests++; if (inflight !== 6'd3) begin fails++; $display("FAIL midflight_count: got %0d want 3", inflight); end
        rst = 1'b0;
        #1;
        tests++; if (inflight !== 6'd0) begin fails++; $display("FAIL midflight_async_clear: got %0d want 0", inflight); end
        step;
        rst = 1'b1;
        for (int j = 0; j <= PL; j++) begin
            tests++; if (resp_valid !== 4'h0 || inflight !== 6'd0) begin fails++; $display("FAIL midflight_discard j=%0d: got valid %h inflight %0d want 0 0", j, resp_valid, inflight); end
            step;
        end
    endtask

    task automatic test_special;
        ops[0] = 32'hBF80_0000; ops[1] = 32'h4080_0000;
        ops[2] = 32'h0000_0000; ops[3] = 32'h7F80_0000;
`ifdef INVSQRT_SCHED_SPECIAL_EN
        exp_dp  = '{32'h0, 32'h4080_0000, 32'h0, 32'h0};
        exp_res = '{32'h7FC0_0000, 32'h3F00_0000, 32'h7F80_0000, 32'h7FC0_0000};
`else
        for (int i = 0; i < 4; i++) begin
            exp_dp[i]  = ops[i];
            exp_res[i] = core_f(ops[i]);
        end
`endif
        req_data = {ops[3], ops[2], ops[1], ops[0]};
        for (int t = 0; t < 4 + PL + 1; t++) begin
            req_valid = (t < 4) ? 4'hF : 4'h0;
            #1;
            if (t < 4) begin
                tests++; if (req_ready !== 4'(1 << t)) begin fails++; $display("FAIL special_grant t=%0d: got %h want %h", t, req_ready, 4'(1 << t)); end
                tests++; if (dp_data_in !== exp_dp[t]) begin fails++; $display("FAIL special_dp_data_in t=%0d: got %h want %h", t, dp_data_in, exp_dp[t]); end
            end
            if (t - PL >= 0 && t - PL < 4) begin
                tests++; if (resp_valid !== 4'(1 << (t - PL))) begin fails++; $display("FAIL special_resp_valid t=%0d: got %h want %h", t, resp_valid, 4'(1 << (t - PL))); end
                tests++; if (resp_data !== exp_res[t - PL]) begin fails++; $display("FAIL special_resp_data t=%0d: got %h want %h", t, resp_data, exp_res[t - PL]); end
            end else begin
                tests++; if (resp_valid !== 4'h0) begin fails++; $display("FAIL special_resp_idle t=%0d: got %h want 0", t, resp_valid); end
            end
            step;
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_flush;
        test_reset_midflight;
        test_special;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
